// File: rtl/picosoc_bus_pkg.sv
// Shared definitions for PicoSoC iomem bus blocks: arbiter state encoding and
// the default error word returned to a master when an access is terminated.
package picosoc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_watchdog.sv
// Access watchdog: counts un-acknowledged cycles of a bus grant and flags the
// cycle on which the access must be forcibly terminated.
module iomem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !ack) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // An acknowledge on the limit cycle completes the access instead of expiring it.
    assign expire = en && !ack && (cnt_q == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iomem_arbiter2.sv
// Two-master round-robin arbiter for the PicoSoC iomem valid/ready bus, with a
// watchdog that terminates accesses the slave never acknowledges.
module iomem_arbiter2
    import picosoc_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        timeout_err,
    output logic [1:0]  grant
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       wd_expire;
    logic       gx_is1;
    logic       gx_valid;

    assign gx_is1   = (state_q == ST_G1);
    assign gx_valid = gx_is1 ? m1_valid : m0_valid;

    iomem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    ((state_q == ST_IDLE) || (state_q == ST_ERR)),
        .en     ((state_q == ST_G0) || (state_q == ST_G1)),
        .ack    (s_ready),
        .expire (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = last_q ? ST_G0 : ST_G1;
                end else if (m0_valid) begin
                    state_d = ST_G0;
                end else if (m1_valid) begin
                    state_d = ST_G1;
                end
            end
            ST_G0, ST_G1: begin
                // A master withdrawing its request forfeits its turn without moving last.
                if (!gx_valid) begin
                    state_d = ST_IDLE;
                end else if (s_ready) begin
                    last_d  = gx_is1;
                    state_d = ST_IDLE;
                end else if (wd_expire) begin
                    // last now names the terminated owner, which ERR uses to route its reply.
                    last_d  = gx_is1;
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = '0;
        m1_rdata    = '0;
        timeout_err = 1'b0;
        grant       = 2'b00;
        case (state_q)
            ST_G0: begin
                s_valid  = m0_valid;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready;
                m0_rdata = s_rdata;
                grant    = 2'b01;
            end
            ST_G1: begin
                s_valid  = m1_valid;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready;
                m1_rdata = s_rdata;
                grant    = 2'b10;
            end
            ST_ERR: begin
                timeout_err = 1'b1;
                if (last_q) begin
                    m1_ready = 1'b1;
                    m1_rdata = ERR_RDATA;
                    grant    = 2'b10;
                end else begin
                    m0_ready = 1'b1;
                    m0_rdata = ERR_RDATA;
                    grant    = 2'b01;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_iomem_arbiter2.sv
// Directed bench for iomem_arbiter2: single access, tie alternation, read path,
// watchdog timeout, ack-on-expiry boundary and asynchronous reset.
module tb_iomem_arbiter2;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        timeout_err;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iomem_arbiter2 #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_valid   (m0_valid),
        .m0_ready   (m0_ready),
        .m0_wstrb   (m0_wstrb),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_ready   (m1_ready),
        .m1_wstrb   (m1_wstrb),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_wstrb    (s_wstrb),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .timeout_err(timeout_err),
        .grant      (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        m0_valid = 1'b0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
        s_ready  = 1'b0; s_rdata  = 32'hFFFF_FFFF;
        #2;
        chk("rst_s_valid", s_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m0_ready", m0_ready, 0);
        chk("rst_m1_ready", m1_ready, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_s_wstrb", s_wstrb, 0);
        tick(); tick();
        reset = 1'b0;
        $display("reset released");

        // tie after reset: m0 first, then m1 after one idle cycle
        m0_valid = 1'b1; m0_addr = 32'h0300_0004; m0_wdata = 32'h11; m0_wstrb = 4'hF;
        m1_valid = 1'b1; m1_addr = 32'h0300_0008; m1_wdata = 32'h22; m1_wstrb = 4'h3;
        #1; chk("tie1_idle_grant", grant, 0);
        tick();
        chk("tie1_first_grant", grant, 2'b01);
        chk("tie1_first_addr", s_addr, 32'h0300_0004);
        s_ready = 1'b1; #1;
        chk("tie1_m0_ready", m0_ready, 1);
        chk("tie1_m1_ready_idle", m1_ready, 0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0; #1;
        chk("tie1_gap_s_valid", s_valid, 0);
        chk("tie1_gap_grant", grant, 0);
        tick();
        chk("tie1_second_grant", grant, 2'b10);
        chk("tie1_second_addr", s_addr, 32'h0300_0008);
        chk("tie1_second_wstrb", s_wstrb, 4'h3);
        s_ready = 1'b1; #1;
        chk("tie1_m1_ready", m1_ready, 1);
        tick();
        m1_valid = 1'b0; s_ready = 1'b0;
        $display("tie1 transaction done");

        // single-master write from m0
        m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wdata = 32'h0000_00A5; m0_wstrb = 4'hF;
        #1; chk("single_T_s_valid", s_valid, 0);
        tick();
        chk("single_T1_s_valid", s_valid, 1);
        chk("single_T1_grant", grant, 2'b01);
        chk("single_T1_wdata", s_wdata, 32'h0000_00A5);
        chk("single_T1_addr", s_addr, 32'h0300_0000);
        chk("single_T1_m0_ready", m0_ready, 0);
        tick();
        s_ready = 1'b1; #1;
        chk("single_T2_m0_ready", m0_ready, 1);
        chk("single_T2_s_valid", s_valid, 1);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0; #1;
        chk("single_T3_no_dup", s_valid, 0);
        tick();
        chk("single_T4_no_dup", s_valid, 0);
        $display("single write transaction done");

        // repeated tie: m0 was served last, so m1 wins
        m0_valid = 1'b1; m1_valid = 1'b1;
        #1; chk("tie2_idle_grant", grant, 0);
        tick();
        chk("tie2_first_grant", grant, 2'b10);
        s_ready = 1'b1; #1;
        chk("tie2_m1_ready", m1_ready, 1);
        chk("tie2_m0_ready", m0_ready, 0);
        tick();
        m1_valid = 1'b0; s_ready = 1'b0; #1;
        chk("tie2_gap_grant", grant, 0);
        tick();
        chk("tie2_second_grant", grant, 2'b01);
        s_ready = 1'b1; #1;
        chk("tie2_m0_ready", m0_ready, 1);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        $display("tie2 transaction done");

        // read path to m1
        m1_valid = 1'b1; m1_addr = 32'h0300_0010; m1_wstrb = 4'h0;
        tick();
        s_rdata = 32'h1234_5678; #1;
        chk("read_wait_m1_ready", m1_ready, 0);
        chk("read_wait_m0_rdata", m0_rdata, 0);
        tick();
        s_ready = 1'b1; #1;
        chk("read_m1_ready", m1_ready, 1);
        chk("read_m1_rdata", m1_rdata, 32'h1234_5678);
        chk("read_m0_rdata", m0_rdata, 0);
        tick();
        m1_valid = 1'b0; s_ready = 1'b0; #1;
        chk("read_after_m1_rdata", m1_rdata, 0);
        $display("read transaction done");

        // timeout on m0: slave never acks
        m0_valid = 1'b1; m0_addr = 32'h0300_0020; m0_wstrb = 4'hF;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("to_wait%0d_grant", k), grant, 2'b01);
            chk($sformatf("to_wait%0d_err", k), timeout_err, 0);
            tick();
        end
        chk("to_err_grant", grant, 2'b01);
        chk("to_err_pulse", timeout_err, 1);
        chk("to_err_m0_ready", m0_ready, 1);
        chk("to_err_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_err_s_valid", s_valid, 0);
        chk("to_err_m1_ready", m1_ready, 0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b1; #1;
        chk("to_late_m0_ready", m0_ready, 0);
        chk("to_late_err", timeout_err, 0);
        chk("to_late_grant", grant, 0);
        tick();
        s_ready = 1'b0; #1;
        chk("to_late_idle_grant", grant, 0);
        $display("timeout transaction done");

        // ack on the exact expiry cycle completes normally
        m1_valid = 1'b1; m1_addr = 32'h0300_0030;
        tick();
        for (int k = 0; k < 7; k++) tick();
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001; #1;
        chk("bnd_m1_ready", m1_ready, 1);
        chk("bnd_m1_rdata", m1_rdata, 32'hCAFE_0001);
        chk("bnd_no_err", timeout_err, 0);
        tick();
        m1_valid = 1'b0; s_ready = 1'b0; #1;
        chk("bnd_after_err", timeout_err, 0);
        chk("bnd_after_grant", grant, 0);
        $display("boundary transaction done");

        // quick m0 access so last points at m0 before the reset test
        m0_valid = 1'b1;
        tick();
        s_ready = 1'b1; #1;
        chk("pre_rst_m0_ready", m0_ready, 1);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;

        // asynchronous reset mid-G1
        m1_valid = 1'b1;
        tick();
        chk("arst_pre_s_valid", s_valid, 1);
        chk("arst_pre_grant", grant, 2'b10);
        #2;
        reset = 1'b1; s_ready = 1'b1; #1;
        chk("arst_s_valid", s_valid, 0);
        chk("arst_grant", grant, 0);
        chk("arst_m1_ready", m1_ready, 0);
        tick();
        reset = 1'b0; s_ready = 1'b0; m1_valid = 1'b0;
        tick();
        m0_valid = 1'b1; m1_valid = 1'b1;
        tick();
        chk("arst_tie_grant", grant, 2'b01);
        s_ready = 1'b1; #1;
        chk("arst_tie_m0_ready", m0_ready, 1);
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        $display("reset transaction done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter2.md
# iomem_arbiter2

Two-master, one-slave arbiter for the PicoSoC `iomem` valid/ready bus. It lets the CPU `iomem` port and a second master (debug or DMA) share the board-level peripheral bus, such as the GPIO/LED register at 0x03xx_xxxx. Grants alternate round-robin, and a grant is held until the transaction completes. A watchdog terminates any access the slave never acknowledges, returning an error word so the master cannot hang.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles in GRANT without `s_ready` before forced termination; legal range 2–65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `m0_valid` in 1, `m0_ready` out 1, `m0_wstrb` in 4, `m0_addr` in 32, `m0_wdata` in 32, `m0_rdata` out 32: master 0 (CPU).
- `m1_valid` in 1, `m1_ready` out 1, `m1_wstrb` in 4, `m1_addr` in 32, `m1_wdata` in 32, `m1_rdata` out 32: master 1.
- `s_valid` out 1, `s_ready` in 1, `s_wstrb` out 4, `s_addr` out 32, `s_wdata` out 32, `s_rdata` in 32: shared slave port.
- `timeout_err` out 1: one-cycle pulse when the watchdog fires.
- `grant` out 2: one-hot current owner, 00 when idle.

## Operation
- **State machine:** IDLE, G0, G1, ERR. All state, the `last` bit and the counter are registered. All bus outputs are combinational from state.
- **IDLE:**
  - `s_valid`=0, `m*_ready`=0.
  - If exactly one `mX_valid` is high, go to GX.
  - If both are high, grant the master ≠ `last`.
- **GX:**
  - `s_valid`=`mX_valid`.
  - `s_addr`, `s_wdata`, `s_wstrb` mux from master X.
  - `mX_ready`=`s_ready`; `mX_rdata`=`s_rdata`. The other master sees ready=0 and rdata=0.
  - On `s_ready`=1: `last`←X, go to IDLE.
  - If `mX_valid` drops without ready (protocol violation): go to IDLE, `last` unchanged.
- **Counter:** 16-bit, cleared on entry to GX, increments each GX cycle without `s_ready`.
  - When it equals `TIMEOUT_CYCLES`−1 and `s_ready`=0: go to ERR.
  - `s_ready` on that same cycle wins; no timeout.
- **ERR (one cycle):**
  - `s_valid`=0.
  - `mX_ready`=1, `mX_rdata`=`ERR_RDATA`; writes are dropped.
  - `timeout_err`=1, `last`←X, then go to IDLE.
- **Stale acknowledges:** `s_ready` seen in IDLE or ERR is ignored. Slaves must abandon an access when `s_valid` falls.
- **`grant`:** one-hot from state; ERR reports the owner being terminated.

## Timing
- **Reset values:** state=IDLE, `last`=1 (so m0 wins the first tie), counter=0. Hence `s_valid`=0, `m*_ready`=0, `m*_rdata`=0, `timeout_err`=0, `grant`=00, `s_addr`/`s_wdata`/`s_wstrb`=0.
- **Arbitration latency:** master valid sampled in IDLE at cycle T → `s_valid` high at T+1.
- **Completion:** `mX_ready` is asserted in the same cycle as `s_ready`, with zero added latency. The state returns to IDLE at the next edge, so `s_valid` is low in the cycle where the master drops valid. This prevents a double access.
- **Back-to-back:** a completed grant always passes through one IDLE cycle. Minimum per-access occupancy is 3 cycles with a registered slave.
- **Timeout:** ERR is entered exactly `TIMEOUT_CYCLES` cycles after GX entry. `mX_ready` pulses in that ERR cycle.
- **Reset mid-transaction:** all outputs drop asynchronously to reset values; the transaction is lost.

## Structure
- **Shared package `picosoc_bus_pkg`:** state encoding constants (IDLE=2'd0, G0=2'd1, G1=2'd2, ERR=2'd3) and the default `ERR_RDATA`. Future bus blocks reuse both.
- **Sub-module `iomem_watchdog`:** the 16-bit counter, with inputs `clr`, `en`, `ack` and output `expire`. It is parameterised by `TIMEOUT_CYCLES` and is reusable for other bus bridges.
- **Top level:** FSM plus mux only.

## Test plan
- **Single master:** m0 writes 32'h0000_00A5 to 0x0300_0000 with wstrb 4'hF; slave acks at cycle 2 after valid. Required: `s_valid` rises at T+1, `m0_ready` coincides with `s_ready`, `grant`=01, no second `s_valid` pulse.
- **Tie after reset:** m0 and m1 both request at the same edge. Required: m0 is served first, then m1 after one IDLE cycle. Repeat the tie and require m1 first (alternation).
- **Read path:** the slave returns 32'h1234_5678 to m1. Required: `m1_rdata`=32'h1234_5678 with `m1_ready`, and `m0_rdata`=0 throughout.
- **Timeout:** `TIMEOUT_CYCLES`=8, slave never acks. Required: ERR is reached 8 cycles after the grant, `m0_ready`=1 with rdata 32'hDEAD_BEEF, `timeout_err` pulses once. A late `s_ready` in the following IDLE is ignored.
- **Boundary:** `s_ready` arrives on the exact expiry cycle. Required: normal completion with slave data and no `timeout_err`.
- **Async reset:** assert `reset` mid-G1 while `s_valid` is high. Required: `s_valid`, `grant` and `m1_ready` go low immediately. After release, the first tie goes to m0.
